// File: rtl/ppa_sklansky_pipe.sv
// Pipelined Sklansky parallel-prefix adder/subtractor with valid/ready flow control.
// Prefix levels are split across a configurable number of register stages.
module ppa_sklansky_pipe #(
   parameter int WIDTH       = 20,
   parameter int PIPE_STAGES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int L  = $clog2(WIDTH);
   localparam int PS = PIPE_STAGES;

   if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
      $error("ppa_sklansky_pipe: WIDTH must be 2..64");
   end
   if (PS < 1 || PS > L + 2) begin : g_bad_stages
      $error("ppa_sklansky_pipe: PIPE_STAGES must be 1..clog2(WIDTH)+2");
   end

   // True when a register sits after prefix level k (k=0 is the p/g stage).
   function automatic bit reg_at(input int k);
      int n;
      int acc;
      bit r;
      r   = 1'b0;
      acc = 0;
      n   = PS - 2;
      if (PS >= 2 && k == 0) r = 1'b1;
      for (int i = 0; i < n; i++) begin
         acc = acc + L / n + ((i < L % n) ? 1 : 0);
         if (k > 0 && acc == k) r = 1'b1;
      end
      return r;
   endfunction

   logic          adv;
   logic [PS-1:0] vld_d;
   logic [PS-1:0] vld_q;

   assign out_valid = vld_q[PS-1];
   assign adv       = ~(vld_q[PS-1] & ~out_ready);
   assign in_ready  = adv;

   always_comb begin
      vld_d = vld_q;
      if (adv) begin
         vld_d    = vld_q << 1;
         vld_d[0] = in_valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_q <= '0;
      else     vld_q <= vld_d;
   end

   for (genvar k = 0; k <= L; k++) begin : g_lvl
      logic [WIDTH-1:0] g_d, p_d, s_d;
      logic             c0_d;
      logic [WIDTH-1:0] g_o, p_o, s_o;
      logic             c0_o;

      if (k == 0) begin : g_pre
         logic [WIDTH-1:0] bb;
         assign bb   = sub ? ~b : b;
         assign p_d  = a ^ bb;
         assign g_d  = a & bb;
         assign s_d  = a ^ bb;
         assign c0_d = cin ^ sub;
      end else begin : g_pfx
         assign s_d  = g_lvl[k-1].s_o;
         assign c0_d = g_lvl[k-1].c0_o;
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i >> (k - 1)) & 1) == 1) begin : g_op
               localparam int M = ((i >> (k - 1)) << (k - 1)) - 1;
               assign g_d[i] = g_lvl[k-1].g_o[i]
                             | (g_lvl[k-1].p_o[i] & g_lvl[k-1].g_o[M]);
               assign p_d[i] = g_lvl[k-1].p_o[i] & g_lvl[k-1].p_o[M];
            end else begin : g_pass
               assign g_d[i] = g_lvl[k-1].g_o[i];
               assign p_d[i] = g_lvl[k-1].p_o[i];
            end
         end
      end

      if (reg_at(k)) begin : g_reg
         logic [WIDTH-1:0] g_q, p_q, s_q;
         logic             c0_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               g_q  <= '0;
               p_q  <= '0;
               s_q  <= '0;
               c0_q <= 1'b0;
            end else if (adv) begin
               g_q  <= g_d;
               p_q  <= p_d;
               s_q  <= s_d;
               c0_q <= c0_d;
            end
         end
         assign g_o  = g_q;
         assign p_o  = p_q;
         assign s_o  = s_q;
         assign c0_o = c0_q;
      end else begin : g_wire
         assign g_o  = g_d;
         assign p_o  = p_d;
         assign s_o  = s_d;
         assign c0_o = c0_d;
      end
   end

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_d, cout_q;
   logic             ovf_d, ovf_q;
   logic             zero_d, zero_q;

   always_comb begin
      c = {g_lvl[L].g_o | (g_lvl[L].p_o & {WIDTH{g_lvl[L].c0_o}}),
           g_lvl[L].c0_o};
      sum_d  = g_lvl[L].s_o ^ c[WIDTH-1:0];
      cout_d = c[WIDTH];
      ovf_d  = c[WIDTH] ^ c[WIDTH-1];
      zero_d = ~|sum_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (adv) begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;
endmodule

// File: tb/tb_ppa_sklansky_pipe.sv
// Bench for ppa_sklansky_pipe: directed table, streaming, stall, reset
// and a multi-configuration random sweep against an arithmetic model.
module tb_ppa_sklansky_pipe;
   localparam int W  = 20;
   localparam int PS = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         in_valid, out_ready, cin, sub;
   logic [W-1:0] a, b;
   logic         in_ready, out_valid, cout, ovf, zero;
   logic [W-1:0] sum;

   ppa_sklansky_pipe #(.WIDTH(W), .PIPE_STAGES(PS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   logic        sw_v, sw_cin, sw_sub, sw_on;
   logic [63:0] sw_a, sw_b;

   logic        s2_rdy, s2_ov, s2_co, s2_of, s2_z;
   logic [1:0]  s2_sum;
   logic        s20_rdy, s20_ov, s20_co, s20_of, s20_z;
   logic [19:0] s20_sum;
   logic        s32_rdy, s32_ov, s32_co, s32_of, s32_z;
   logic [31:0] s32_sum;
   logic        s64_rdy, s64_ov, s64_co, s64_of, s64_z;
   logic [63:0] s64_sum;

   ppa_sklansky_pipe #(.WIDTH(2), .PIPE_STAGES(3)) u_w2 (
      .clk(clk), .rst(rst), .in_valid(sw_v), .in_ready(s2_rdy),
      .a(sw_a[1:0]), .b(sw_b[1:0]), .cin(sw_cin), .sub(sw_sub),
      .out_valid(s2_ov), .out_ready(1'b1), .sum(s2_sum), .cout(s2_co),
      .ovf(s2_of), .zero(s2_z)
   );
   ppa_sklansky_pipe #(.WIDTH(20), .PIPE_STAGES(1)) u_w20 (
      .clk(clk), .rst(rst), .in_valid(sw_v), .in_ready(s20_rdy),
      .a(sw_a[19:0]), .b(sw_b[19:0]), .cin(sw_cin), .sub(sw_sub),
      .out_valid(s20_ov), .out_ready(1'b1), .sum(s20_sum), .cout(s20_co),
      .ovf(s20_of), .zero(s20_z)
   );
   ppa_sklansky_pipe #(.WIDTH(32), .PIPE_STAGES(7)) u_w32 (
      .clk(clk), .rst(rst), .in_valid(sw_v), .in_ready(s32_rdy),
      .a(sw_a[31:0]), .b(sw_b[31:0]), .cin(sw_cin), .sub(sw_sub),
      .out_valid(s32_ov), .out_ready(1'b1), .sum(s32_sum), .cout(s32_co),
      .ovf(s32_of), .zero(s32_z)
   );
   ppa_sklansky_pipe #(.WIDTH(64), .PIPE_STAGES(8)) u_w64 (
      .clk(clk), .rst(rst), .in_valid(sw_v), .in_ready(s64_rdy),
      .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
      .out_valid(s64_ov), .out_ready(1'b1), .sum(s64_sum), .cout(s64_co),
      .ovf(s64_of), .zero(s64_z)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [66:0] got,
                      input logic [66:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // Reference: {ovf, zero, cout, sum} for a w-bit add/sub.
   function automatic logic [66:0] gold(input int w, input logic [63:0] x,
                                        input logic [63:0] y,
                                        input logic ci, input logic sb);
      logic [64:0] msk, xx, yy, full;
      logic [63:0] s, t;
      logic        co, cm;
      msk  = (65'd1 << w) - 65'd1;
      xx   = {1'b0, x} & msk;
      yy   = {1'b0, sb ? ~y : y} & msk;
      full = xx + yy + {64'd0, ci ^ sb};
      s    = full[63:0] & msk[63:0];
      t    = 64'((full >> w) & 65'd1);
      co   = t[0];
      t    = (xx[63:0] ^ yy[63:0] ^ s) >> (w - 1);
      cm   = t[0];
      return {co ^ cm, s == 64'd0, co, s};
   endfunction

   function automatic logic [66:0] main_out();
      return {ovf, zero, cout, 44'd0, sum};
   endfunction

   typedef struct {
      logic [19:0] a;
      logic [19:0] b;
      logic        cin;
      logic        sub;
      logic [19:0] s;
      logic        co;
      logic        of;
      logic        z;
   } vec_t;

   vec_t vt[11];

   task automatic run_vec(input vec_t v, input int idx);
      int n;
      a = v.a; b = v.b; cin = v.cin; sub = v.sub;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk($sformatf("v%0d_lat", idx), 67'(n), 67'(PS));
      chk($sformatf("v%0d_sum", idx), 67'(sum), 67'(v.s));
      chk($sformatf("v%0d_cout", idx), 67'(cout), 67'(v.co));
      chk($sformatf("v%0d_ovf", idx), 67'(ovf), 67'(v.of));
      chk($sformatf("v%0d_zero", idx), 67'(zero), 67'(v.z));
   endtask

   logic [66:0] q2[$], q20[$], q32[$], q64[$];

   always @(negedge clk) begin
      logic [66:0] e;
      if (sw_on && !rst) begin
         if (sw_v)
            chk("sw_rdy", 67'(s2_rdy & s20_rdy & s32_rdy & s64_rdy), 67'd1);
         if (s2_ov) begin
            if (q2.size() > 0) e = q2.pop_front(); else e = '1;
            chk("sw_w2", {s2_of, s2_z, s2_co, 62'd0, s2_sum}, e);
         end
         if (s20_ov) begin
            if (q20.size() > 0) e = q20.pop_front(); else e = '1;
            chk("sw_w20", {s20_of, s20_z, s20_co, 44'd0, s20_sum}, e);
         end
         if (s32_ov) begin
            if (q32.size() > 0) e = q32.pop_front(); else e = '1;
            chk("sw_w32", {s32_of, s32_z, s32_co, 32'd0, s32_sum}, e);
         end
         if (s64_ov) begin
            if (q64.size() > 0) e = q64.pop_front(); else e = '1;
            chk("sw_w64", {s64_of, s64_z, s64_co, s64_sum}, e);
         end
      end
   end

   logic [19:0] oa[8], ob[8];
   logic        oc[8], os[8];
   logic [66:0] oe[8];

   initial begin
      #2000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      int got, first, last, stale;
      logic xfer;

      vt[0]  = '{20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, 1'b1};
      vt[1]  = '{20'h7FFFF, 20'h00001, 1'b0, 1'b0, 20'h80000, 1'b0, 1'b1, 1'b0};
      vt[2]  = '{20'h00005, 20'h00007, 1'b0, 1'b1, 20'hFFFFE, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{20'h12345, 20'h54321, 1'b1, 1'b0, 20'h66667, 1'b0, 1'b0, 1'b0};
      vt[4]  = '{20'h80000, 20'h80000, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b1, 1'b1};
      vt[5]  = '{20'h00003, 20'h00003, 1'b0, 1'b1, 20'h00000, 1'b1, 1'b0, 1'b1};
      vt[6]  = '{20'h00000, 20'h00001, 1'b0, 1'b1, 20'hFFFFF, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{20'h80000, 20'h00001, 1'b0, 1'b1, 20'h7FFFF, 1'b1, 1'b1, 1'b0};
      vt[8]  = '{20'h0000A, 20'h00003, 1'b1, 1'b1, 20'h00006, 1'b1, 1'b0, 1'b0};
      vt[9]  = '{20'h00000, 20'h00000, 1'b1, 1'b0, 20'h00001, 1'b0, 1'b0, 1'b0};
      vt[10] = '{20'hAAAAA, 20'h55555, 1'b1, 1'b0, 20'h00000, 1'b1, 1'b0, 1'b1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      sw_v = 1'b0; sw_on = 1'b0; sw_a = '0; sw_b = '0;
      sw_cin = 1'b0; sw_sub = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", {ovf, zero, cout, out_valid, 43'd0, sum}, 67'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_ready", 67'(in_ready), 67'd1);

      for (int i = 0; i < 11; i++) run_vec(vt[i], i);
      repeat (3) @(posedge clk);
      #1;

      // streaming: 8 back-to-back operations
      for (int n = 0; n < 8; n++) begin
         oa[n] = 20'($urandom()); ob[n] = 20'($urandom());
         oc[n] = 1'($urandom()); os[n] = 1'($urandom());
         oe[n] = gold(20, {44'd0, oa[n]}, {44'd0, ob[n]}, oc[n], os[n]);
      end
      got = 0; first = -1; last = -1;
      fork
         begin
            for (int n = 0; n < 8; n++) begin
               a = oa[n]; b = ob[n]; cin = oc[n]; sub = os[n];
               in_valid = 1'b1;
               @(posedge clk); #1;
            end
            in_valid = 1'b0;
         end
         begin
            for (int e = 1; e <= 14; e++) begin
               @(posedge clk);
               @(negedge clk);
               if (out_valid) begin
                  if (first < 0) first = e;
                  last = e;
                  if (got < 8) chk($sformatf("b2b_res%0d", got), main_out(), oe[got]);
                  got++;
               end
            end
         end
      join
      chk("b2b_first", 67'(first), 67'd3);
      chk("b2b_last", 67'(last), 67'd10);
      chk("b2b_count", 67'(got), 67'd8);
      @(posedge clk); #1;

      // stall with the pipe full
      for (int n = 0; n < 4; n++) begin
         oa[n] = 20'(n * 20'h11111 + 1); ob[n] = 20'(20'hFFFF0 - n * 3);
         oc[n] = n[0]; os[n] = n[1];
         oe[n] = gold(20, {44'd0, oa[n]}, {44'd0, ob[n]}, oc[n], os[n]);
      end
      out_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         a = oa[n]; b = ob[n]; cin = oc[n]; sub = os[n];
         in_valid = 1'b1;
         chk("stall_fill_rdy", 67'(in_ready), 67'd1);
         @(posedge clk); #1;
      end
      a = oa[3]; b = ob[3]; cin = oc[3]; sub = os[3];
      chk("stall_ov", 67'(out_valid), 67'd1);
      chk("stall_in_ready", 67'(in_ready), 67'd0);
      chk("stall_res0", main_out(), oe[0]);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk("stall_hold_rdy", 67'(in_ready), 67'd0);
         chk("stall_hold", {out_valid, main_out()}, {1'b1, oe[0]});
      end
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         xfer = in_valid && in_ready;
         if (out_valid && out_ready) begin
            if (got < 4) chk($sformatf("stall_out%0d", got), main_out(), oe[got]);
            got++;
         end
         @(posedge clk); #1;
         if (xfer) in_valid = 1'b0;
      end
      chk("stall_count", 67'(got), 67'd4);

      // reset while stalled with operands in flight
      out_ready = 1'b0;
      a = 20'h12345; b = 20'h00001; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      a = 20'h00F00; b = 20'h000FF;
      @(posedge clk); #1;
      a = 20'h11111; b = 20'h22222;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("prerst_ov", {out_valid, main_out()},
          {1'b1, 3'b000, 44'd0, 20'h12346});
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_out", {ovf, zero, cout, out_valid, 43'd0, sum}, 67'd0);
      chk("rst_async_rdy", 67'(in_ready), 67'd1);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      stale = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      chk("rst_no_stale", 67'(stale), 67'd0);
      @(posedge clk); #1;
      run_vec(vt[3], 100);

      // random sweep across several widths and depths
      repeat (2) @(posedge clk);
      #1;
      sw_on = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         sw_a   = {$urandom(), $urandom()};
         sw_b   = {$urandom(), $urandom()};
         sw_cin = 1'($urandom());
         sw_sub = 1'($urandom());
         if (n % 97 == 0) sw_b = sw_a;
         if (n % 101 == 0) sw_a = '1;
         sw_v = 1'b1;
         q2.push_back(gold(2, sw_a, sw_b, sw_cin, sw_sub));
         q20.push_back(gold(20, sw_a, sw_b, sw_cin, sw_sub));
         q32.push_back(gold(32, sw_a, sw_b, sw_cin, sw_sub));
         q64.push_back(gold(64, sw_a, sw_b, sw_cin, sw_sub));
         @(posedge clk); #1;
      end
      sw_v = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("sw_drain", 67'(q2.size() + q20.size() + q32.size() + q64.size()), 67'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
